ctrl_code_gen_s4_param: RTL and testbench
=========================================

// Module: ctrl_code_gen_s4_param
// PURPOSE
//  Parametrised stage-4 control-code generator for the pipelined RISC core. Registers a decoded
//  control word from the stage-3/4 opcode buffer, resolves conditional branch/call/return using the
//  registered selected flag, and drives write-back/SP/output enables. Adds stall/flush, a valid bit,
//  one-hot RN select, a KILL_DEPTH-deep post-redirect squash counter and a saturating squash counter.
// PARAMETERS
//  OPCODE_W    8  opcode width; decode uses opcode[7:0], upper bits must be 0 or the word decodes as NOP
//  RN_W        3  register-index width taken from opcode[RN_W-1:0]; rn_sel width is 2**RN_W
//  KILL_DEPTH  2  instructions squashed after a taken redirect (0 disables squash; max 15)
//  CNT_W       16 width of squash_count (saturates at all-ones)
// PORTS
//  clk         in  1          global clock, all state on posedge
//  rst         in  1          synchronous active-high reset
//  opcode      in  OPCODE_W   from opcode buffer 34
//  in_valid    in  1          opcode is a real instruction
//  FL          in  1          selected flag for this instruction
//  stall       in  1          hold all stage state
//  flush       in  1          replace stage content with bubble
//  WR,FLRN,LRN,LR0,LSP,LOP,ERN,EFL out 1 each  control bits (registered, gated by valid)
//  DSP_out     out 1          SP-1 pass-through, condition-resolved
//  ISP_out     out 1          SP+1, condition-resolved
//  rn_sel      out 2**RN_W    one-hot register select, zero when !valid_out
//  valid_out   out 1          stage holds a live instruction
//  redirect    out 1          one-cycle pulse: taken branch/call/return
//  squash_count out CNT_W     total instructions squashed by kill window
// BEHAVIOUR
//  Control word cw = {WR,FLRN,LRN,LR0,LSP,DSP,LOP,ERN,EFL,ISP,BR}; casex, first match wins:
//   00000000 NOP,00000010 CLC: 0 | 00000001 CLR: FLRN,LRN,LR0 | 00000011/100 JUD/JUA: BR
//   00000101/110 CUD/CUA: WR,DSP,BR | 00000111 RTU: ISP,BR | 00001xxx JCD, 00101xxx JCA: EFL,BR
//   00010000 LSP: LSP | 00010xxx MVD: FLRN,LRN | 00011000 RSP: LR0 | 00011xxx MVS: LR0,ERN
//   00100xxx NOT,01000xxx INC,01010xxx DCR, 1xxx1xxx imm-ALU: FLRN,LRN,ERN | 01011xxx MVI: FLRN,LRN
//   00110xxx/00111xxx CCD/CCA: WR,DSP,EFL,BR | 01001xxx RTC: EFL,ISP,BR
//   01100000 RLA, 01110000 RRA, 11110xxx INA: LR0 | 01100xxx STA: WR,ERN | 01101xxx PSH: WR,DSP,ERN
//   01110xxx LDA: FLRN,LRN | 01111xxx POP: FLRN,LRN,ISP | 1xxx0xxx (1000..1110) acc-ALU: LR0,ERN
//   11111xxx OUT: LOP
//  Register update each posedge, priority: rst > flush > stall > advance.
//   rst: cw,fl_q,rn_q,valid,kill_cnt,squash_count <= 0. All outputs 0 the same edge.
//   flush: cw<=0, valid<=0, kill_cnt<=0; squash_count unchanged. Flush beats simultaneous redirect.
//   stall: everything held; redirect forced 0 (no double pulse); kill_cnt held.
//   advance, kill_cnt>0: load bubble, kill_cnt--, squash_count++ if in_valid (saturating).
//   advance, kill_cnt==0: cw<=decode(opcode), valid<=in_valid, fl_q<=FL, rn_q<=opcode[RN_W-1:0].
//   advance and redirect this cycle: kill_cnt<=KILL_DEPTH (overrides decrement).
//  Latency: opcode/FL at edge N -> outputs valid after edge N (1 cycle).
//  Resolution (combinational from regs): fail = EFL_q & ~fl_q.
//   WR = valid&WR_q&~fail; DSP_out = valid&((ISP_q&EFL_q&~fl_q)|(DSP_q&~fail));
//   ISP_out = valid&ISP_q&~fail; redirect = valid&BR_q&~fail&~stall; others = valid&bit.
//  rn_sel = valid ? (1<<rn_q) : 0. Unconditional ops: EFL_q=0 so fail=0.
// TESTING
//  rst high 2 cycles with opcode=8'h6D -> all outputs 0, squash_count=0, valid_out=0.
//  PSH r5 (8'h6D), in_valid=1 -> next cycle WR=1,DSP_out=1,ERN=1,rn_sel=8'h20, redirect=0.
//  CCD (8'h33) FL=0 -> WR=0,DSP_out=0,redirect=0; FL=1 -> WR=1,DSP_out=1,redirect=1 one cycle.
//  JUD then 3 valid INCs, KILL_DEPTH=2 -> 2 INCs squashed (valid_out=0), 3rd live, squash_count=2.
//  RTC FL=1 with stall held 3 cycles -> redirect 0 during stall, single pulse on release edge.
//  Redirect cycle with flush=1 -> next cycle valid_out=0, kill_cnt=0, following opcode live.

Source files
------------

// File: rtl/ctrl_code_gen_s4_param.sv
// Stage-4 control-code generator: registers the decoded control word, resolves conditional
// branch/call/return against the registered flag and squashes the instructions after a redirect.
module ctrl_code_gen_s4_param #(
  parameter int OPCODE_W   = 8,
  parameter int RN_W       = 3,
  parameter int KILL_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic                  in_valid,
  input  logic                  FL,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  WR,
  output logic                  FLRN,
  output logic                  LRN,
  output logic                  LR0,
  output logic                  LSP,
  output logic                  LOP,
  output logic                  ERN,
  output logic                  EFL,
  output logic                  DSP_out,
  output logic                  ISP_out,
  output logic [(2**RN_W)-1:0]  rn_sel,
  output logic                  valid_out,
  output logic                  redirect,
  output logic [CNT_W-1:0]      squash_count
);

  localparam int RN_N = 2**RN_W;
  localparam int KW   = 4;
  localparam logic [KW-1:0] KILL_INIT = KW'(KILL_DEPTH);

  // Control-word bit masks, cw = {WR,FLRN,LRN,LR0,LSP,DSP,LOP,ERN,EFL,ISP,BR}
  localparam logic [10:0] M_WR   = 11'b100_0000_0000;
  localparam logic [10:0] M_FLRN = 11'b010_0000_0000;
  localparam logic [10:0] M_LRN  = 11'b001_0000_0000;
  localparam logic [10:0] M_LR0  = 11'b000_1000_0000;
  localparam logic [10:0] M_LSP  = 11'b000_0100_0000;
  localparam logic [10:0] M_DSP  = 11'b000_0010_0000;
  localparam logic [10:0] M_LOP  = 11'b000_0001_0000;
  localparam logic [10:0] M_ERN  = 11'b000_0000_1000;
  localparam logic [10:0] M_EFL  = 11'b000_0000_0100;
  localparam logic [10:0] M_ISP  = 11'b000_0000_0010;
  localparam logic [10:0] M_BR   = 11'b000_0000_0001;

  // OUT and INA are listed ahead of the wider ALU patterns so they stay reachable.
  function automatic logic [10:0] decode_cw(input logic [7:0] op);
    logic [10:0] cw;
    cw = 11'b0;
    casez (op)
      8'b0000_0000, 8'b0000_0010: cw = 11'b0;
      8'b0000_0001:               cw = M_FLRN | M_LRN | M_LR0;
      8'b0000_0011, 8'b0000_0100: cw = M_BR;
      8'b0000_0101, 8'b0000_0110: cw = M_WR | M_DSP | M_BR;
      8'b0000_0111:               cw = M_ISP | M_BR;
      8'b0000_1???, 8'b0010_1???: cw = M_EFL | M_BR;
      8'b0001_0000:               cw = M_LSP;
      8'b0001_0???:               cw = M_FLRN | M_LRN;
      8'b0001_1000:               cw = M_LR0;
      8'b0001_1???:               cw = M_LR0 | M_ERN;
      8'b1111_1???:               cw = M_LOP;
      8'b1111_0???:               cw = M_LR0;
      8'b0010_0???, 8'b0100_0???, 8'b0101_0???, 8'b1???_1???:
                                  cw = M_FLRN | M_LRN | M_ERN;
      8'b0101_1???:               cw = M_FLRN | M_LRN;
      8'b0011_????:               cw = M_WR | M_DSP | M_EFL | M_BR;
      8'b0100_1???:               cw = M_EFL | M_ISP | M_BR;
      8'b0110_0000, 8'b0111_0000: cw = M_LR0;
      8'b0110_0???:               cw = M_WR | M_ERN;
      8'b0110_1???:               cw = M_WR | M_DSP | M_ERN;
      8'b0111_0???:               cw = M_FLRN | M_LRN;
      8'b0111_1???:               cw = M_FLRN | M_LRN | M_ISP;
      8'b1???_0???:               cw = M_LR0 | M_ERN;
      default:                    cw = 11'b0;
    endcase
    return cw;
  endfunction

  logic [10:0]      cw_r;
  logic             fl_r;
  logic [RN_W-1:0]  rn_r;
  logic             valid_r;
  logic [KW-1:0]    kill_cnt_r;
  logic [CNT_W-1:0] squash_count_r;
  logic             hi_zero_s;
  logic [10:0]      dec_s;
  logic             fail_s;
  logic             redirect_s;

  assign hi_zero_s = ((opcode >> 8) == '0);
  assign dec_s     = hi_zero_s ? decode_cw(opcode[7:0]) : 11'b0;

  // A conditional op fails when its flag-enable is set and the selected flag is clear.
  assign fail_s     = cw_r[2] & ~fl_r;
  assign redirect_s = valid_r & cw_r[0] & ~fail_s & ~stall;

  assign WR           = valid_r & cw_r[10] & ~fail_s;
  assign FLRN         = valid_r & cw_r[9];
  assign LRN          = valid_r & cw_r[8];
  assign LR0          = valid_r & cw_r[7];
  assign LSP          = valid_r & cw_r[6];
  assign LOP          = valid_r & cw_r[4];
  assign ERN          = valid_r & cw_r[3];
  assign EFL          = valid_r & cw_r[2];
  assign DSP_out      = valid_r & ((cw_r[1] & cw_r[2] & ~fl_r) | (cw_r[5] & ~fail_s));
  assign ISP_out      = valid_r & cw_r[1] & ~fail_s;
  assign rn_sel       = valid_r ? ({{(RN_N-1){1'b0}}, 1'b1} << rn_r) : {RN_N{1'b0}};
  assign valid_out    = valid_r;
  assign redirect     = redirect_s;
  assign squash_count = squash_count_r;

  // Stage register update: rst > flush > stall > advance (with post-redirect kill window).
  always_ff @(posedge clk) begin
    if (rst) begin
      cw_r           <= 11'b0;
      fl_r           <= 1'b0;
      rn_r           <= '0;
      valid_r        <= 1'b0;
      kill_cnt_r     <= '0;
      squash_count_r <= '0;
    end else if (flush) begin
      cw_r       <= 11'b0;
      valid_r    <= 1'b0;
      kill_cnt_r <= '0;
    end else if (!stall) begin
      if (kill_cnt_r != '0) begin
        cw_r       <= 11'b0;
        valid_r    <= 1'b0;
        kill_cnt_r <= kill_cnt_r - KW'(1);
        if (in_valid && (squash_count_r != {CNT_W{1'b1}})) begin
          squash_count_r <= squash_count_r + CNT_W'(1);
        end
      end else begin
        cw_r    <= dec_s;
        valid_r <= in_valid;
        fl_r    <= FL;
        rn_r    <= opcode[RN_W-1:0];
      end
      if (redirect_s) begin
        kill_cnt_r <= KILL_INIT;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_code_gen_s4_param.sv
// Directed bench for ctrl_code_gen_s4_param: decode table vectors, then reset, kill-window,
// stall and flush sequences.
module tb_ctrl_code_gen_s4_param;

  logic        clk = 1'b0;
  logic        rst, in_valid, FL, stall, flush;
  logic [7:0]  opcode;
  logic        WR, FLRN, LRN, LR0, LSP, LOP, ERN, EFL, DSP_out, ISP_out, valid_out, redirect;
  logic [7:0]  rn_sel;
  logic [15:0] squash_count;

  int n_checks = 0;
  int n_fail   = 0;

  ctrl_code_gen_s4_param #(.OPCODE_W(8), .RN_W(3), .KILL_DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .in_valid(in_valid), .FL(FL),
    .stall(stall), .flush(flush),
    .WR(WR), .FLRN(FLRN), .LRN(LRN), .LR0(LR0), .LSP(LSP), .LOP(LOP), .ERN(ERN), .EFL(EFL),
    .DSP_out(DSP_out), .ISP_out(ISP_out), .rn_sel(rn_sel), .valid_out(valid_out),
    .redirect(redirect), .squash_count(squash_count)
  );

  always #5 clk = ~clk;

  // {WR,FLRN,LRN,LR0,LSP,LOP,ERN,EFL,DSP_out,ISP_out,redirect,valid_out}
  logic [11:0] obs;
  assign obs = {WR, FLRN, LRN, LR0, LSP, LOP, ERN, EFL, DSP_out, ISP_out, redirect, valid_out};

  typedef struct {
    logic [7:0]  op;
    logic        fl;
    logic        iv;
    logic [11:0] exp;
    logic [7:0]  rn;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic iv, input logic f);
    opcode   = op;
    in_valid = iv;
    FL       = f;
  endtask

  initial begin
    vecs[0]  = '{8'h6D, 1'b0, 1'b1, 12'h829, 8'h20};  // PSH r5
    vecs[1]  = '{8'h33, 1'b0, 1'b1, 12'h011, 8'h08};  // CCD, flag clear
    vecs[2]  = '{8'h33, 1'b1, 1'b1, 12'h81B, 8'h08};  // CCD, flag set
    vecs[3]  = '{8'h01, 1'b0, 1'b1, 12'h701, 8'h02};  // CLR
    vecs[4]  = '{8'h4A, 1'b0, 1'b1, 12'h019, 8'h04};  // RTC not taken: DSP_out restores SP
    vecs[5]  = '{8'h4A, 1'b1, 1'b1, 12'h017, 8'h04};  // RTC taken
    vecs[6]  = '{8'h07, 1'b0, 1'b1, 12'h007, 8'h80};  // RTU
    vecs[7]  = '{8'h10, 1'b0, 1'b1, 12'h081, 8'h01};  // LSP
    vecs[8]  = '{8'h18, 1'b0, 1'b1, 12'h101, 8'h01};  // RSP
    vecs[9]  = '{8'h1B, 1'b0, 1'b1, 12'h121, 8'h08};  // MVS
    vecs[10] = '{8'h60, 1'b0, 1'b1, 12'h101, 8'h01};  // RLA
    vecs[11] = '{8'h61, 1'b0, 1'b1, 12'h821, 8'h02};  // STA
    vecs[12] = '{8'h7C, 1'b0, 1'b1, 12'h605, 8'h10};  // POP
    vecs[13] = '{8'h8A, 1'b0, 1'b1, 12'h621, 8'h04};  // imm-ALU
    vecs[14] = '{8'h92, 1'b0, 1'b1, 12'h121, 8'h04};  // acc-ALU
    vecs[15] = '{8'hF1, 1'b0, 1'b1, 12'h101, 8'h02};  // INA
    vecs[16] = '{8'h0C, 1'b1, 1'b1, 12'h013, 8'h10};  // JCD taken
    vecs[17] = '{8'h0C, 1'b0, 1'b1, 12'h011, 8'h10};  // JCD not taken
    vecs[18] = '{8'h6D, 1'b0, 1'b0, 12'h000, 8'h00};  // not a real instruction
    vecs[19] = '{8'h00, 1'b0, 1'b1, 12'h001, 8'h01};  // NOP
    vecs[20] = '{8'h5A, 1'b0, 1'b1, 12'h601, 8'h04};  // MVI
    vecs[21] = '{8'h2B, 1'b1, 1'b1, 12'h013, 8'h08};  // JCA taken

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(8'h6D, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("reset_outputs", {20'd0, obs}, 32'd0);
      chk("reset_rn_sel", {24'd0, rn_sel}, 32'd0);
      chk("reset_squash", {16'd0, squash_count}, 32'd0);
    end
    rst = 1'b0;

    // Each vector is isolated by a flush so any redirect's kill window is cleared.
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].op, vecs[i].iv, vecs[i].fl);
      tick();
      chk($sformatf("vec%0d_ctrl", i), {20'd0, obs}, {20'd0, vecs[i].exp});
      chk($sformatf("vec%0d_rn_sel", i), {24'd0, rn_sel}, {24'd0, vecs[i].rn});
      flush = 1'b1;
      drive(8'h00, 1'b0, 1'b0);
      tick();
      flush = 1'b0;
      chk($sformatf("vec%0d_flushed", i), {31'd0, valid_out}, 32'd0);
    end
    chk("squash_after_table", {16'd0, squash_count}, 32'd0);

    // Kill window: JUD, a non-valid slot at the redirect edge, then three INCs.
    drive(8'h03, 1'b1, 1'b0);
    tick();
    chk("jud_redirect", {31'd0, redirect}, 32'd1);
    drive(8'h00, 1'b0, 1'b0);
    tick();
    chk("kill_slot_valid", {31'd0, valid_out}, 32'd0);
    chk("kill_slot_redirect", {31'd0, redirect}, 32'd0);
    drive(8'h40, 1'b1, 1'b0);
    tick();
    chk("inc1_squashed", {31'd0, valid_out}, 32'd0);
    chk("inc1_squash_count", {16'd0, squash_count}, 32'd1);
    tick();
    chk("inc2_squashed", {31'd0, valid_out}, 32'd0);
    chk("inc2_squash_count", {16'd0, squash_count}, 32'd2);
    tick();
    chk("inc3_live", {20'd0, obs}, 32'h621);
    chk("inc3_squash_count", {16'd0, squash_count}, 32'd2);

    // Stall holding a taken RTC: no redirect until stall drops, then a single pulse.
    flush = 1'b1; tick(); flush = 1'b0;
    drive(8'h4A, 1'b1, 1'b1);
    tick();
    stall = 1'b1;
    drive(8'h6D, 1'b1, 1'b0);
    #1;
    chk("stall_redirect_0", {31'd0, redirect}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_hold%0d_redirect", i), {31'd0, redirect}, 32'd0);
      chk($sformatf("stall_hold%0d_isp", i), {31'd0, ISP_out}, 32'd1);
    end
    stall = 1'b0;
    #1;
    chk("stall_release_redirect", {31'd0, redirect}, 32'd1);
    chk("stall_release_isp", {31'd0, ISP_out}, 32'd1);
    drive(8'h00, 1'b0, 1'b0);
    tick();
    chk("stall_no_double_pulse", {31'd0, redirect}, 32'd0);
    chk("stall_squash_unchanged", {16'd0, squash_count}, 32'd2);

    // Flush during a redirect cycle cancels the kill window.
    flush = 1'b1; tick(); flush = 1'b0;
    drive(8'h03, 1'b1, 1'b0);
    tick();
    chk("flush_pre_redirect", {31'd0, redirect}, 32'd1);
    flush = 1'b1;
    drive(8'h40, 1'b1, 1'b0);
    tick();
    flush = 1'b0;
    chk("flush_valid", {31'd0, valid_out}, 32'd0);
    chk("flush_redirect", {31'd0, redirect}, 32'd0);
    drive(8'h40, 1'b1, 1'b0);
    tick();
    chk("after_flush_live", {20'd0, obs}, 32'h621);
    chk("after_flush_squash", {16'd0, squash_count}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
